// File: rtl/split_2_pkg.sv
// Shared constants for the split_2 assignment loader: variable widths,
// bit offsets of var_0..var_19 inside the 512-bit frame, and loader states.
package split_2_pkg;

    localparam int FRAME_BITS  = 512;
    localparam int FRAME_WORDS = 16;
    localparam int NUM_VARS    = 20;

    localparam int VAR_W [NUM_VARS] = '{
        28, 24, 27, 26, 17, 20, 30, 25, 26, 30,
        30, 32, 32, 21, 19, 19, 32, 24, 26, 24
    };

    // Prefix sums of VAR_W; the last variable ends exactly at bit 511.
    localparam int OFF [NUM_VARS] = '{
        0,   28,  52,  79,  105, 122, 142, 172, 197, 223,
        253, 283, 315, 347, 368, 387, 406, 438, 462, 488
    };

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/split_2_assign_unpack.sv
// Combinational slicer: splits the packed frame into var_0..var_19
// using the package offsets and widths.
module split_2_assign_unpack
    import split_2_pkg::*;
(
    input  logic [FRAME_BITS-1:0] var_bus,
    output logic [VAR_W[0]-1:0]   var_0,
    output logic [VAR_W[1]-1:0]   var_1,
    output logic [VAR_W[2]-1:0]   var_2,
    output logic [VAR_W[3]-1:0]   var_3,
    output logic [VAR_W[4]-1:0]   var_4,
    output logic [VAR_W[5]-1:0]   var_5,
    output logic [VAR_W[6]-1:0]   var_6,
    output logic [VAR_W[7]-1:0]   var_7,
    output logic [VAR_W[8]-1:0]   var_8,
    output logic [VAR_W[9]-1:0]   var_9,
    output logic [VAR_W[10]-1:0]  var_10,
    output logic [VAR_W[11]-1:0]  var_11,
    output logic [VAR_W[12]-1:0]  var_12,
    output logic [VAR_W[13]-1:0]  var_13,
    output logic [VAR_W[14]-1:0]  var_14,
    output logic [VAR_W[15]-1:0]  var_15,
    output logic [VAR_W[16]-1:0]  var_16,
    output logic [VAR_W[17]-1:0]  var_17,
    output logic [VAR_W[18]-1:0]  var_18,
    output logic [VAR_W[19]-1:0]  var_19
);

    assign var_0  = var_bus[OFF[0]  +: VAR_W[0]];
    assign var_1  = var_bus[OFF[1]  +: VAR_W[1]];
    assign var_2  = var_bus[OFF[2]  +: VAR_W[2]];
    assign var_3  = var_bus[OFF[3]  +: VAR_W[3]];
    assign var_4  = var_bus[OFF[4]  +: VAR_W[4]];
    assign var_5  = var_bus[OFF[5]  +: VAR_W[5]];
    assign var_6  = var_bus[OFF[6]  +: VAR_W[6]];
    assign var_7  = var_bus[OFF[7]  +: VAR_W[7]];
    assign var_8  = var_bus[OFF[8]  +: VAR_W[8]];
    assign var_9  = var_bus[OFF[9]  +: VAR_W[9]];
    assign var_10 = var_bus[OFF[10] +: VAR_W[10]];
    assign var_11 = var_bus[OFF[11] +: VAR_W[11]];
    assign var_12 = var_bus[OFF[12] +: VAR_W[12]];
    assign var_13 = var_bus[OFF[13] +: VAR_W[13]];
    assign var_14 = var_bus[OFF[14] +: VAR_W[14]];
    assign var_15 = var_bus[OFF[15] +: VAR_W[15]];
    assign var_16 = var_bus[OFF[16] +: VAR_W[16]];
    assign var_17 = var_bus[OFF[17] +: VAR_W[17]];
    assign var_18 = var_bus[OFF[18] +: VAR_W[18]];
    assign var_19 = var_bus[OFF[19] +: VAR_W[19]];

endmodule

// File: rtl/split_2_assign_loader.sv
// Assembles a 16-word assignment frame onto var_bus, waits for the split_2
// checker to settle, samples chk_x and returns one verdict per frame.
//
// state     | meaning
// LOAD      | accepting frame words into var_bus
// DRAIN     | frame overran 16 words; discard until s_last
// SETTLE    | bus stable, counting CHECK_LAT+1 cycles before sampling chk_x
// REPORT    | verdict presented on m_*, waiting for m_ready
module split_2_assign_loader
    import split_2_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHECK_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_last,
    output logic [FRAME_BITS-1:0] var_bus,
    input  logic                  chk_x,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_pass,
    output logic                  m_err,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt
);

    localparam int IDX_W = $clog2(FRAME_WORDS);
    localparam logic [3:0] LAT_INIT = 4'(CHECK_LAT);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [3:0]       lat_cnt;
    logic             err;
    logic             ready_en;
    logic             s_hs, m_hs, last_word;

    assign last_word = (idx == IDX_W'(FRAME_WORDS - 1));
    assign s_hs      = s_valid & s_ready;
    assign m_hs      = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        case (state)
            ST_LOAD: begin
                s_ready = ready_en;
                if (s_hs) begin
                    if (s_last)         state_nxt = ST_SETTLE;
                    else if (last_word) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                s_ready = ready_en;
                if (s_hs && s_last) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (lat_cnt == 4'd0) state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                m_valid = 1'b1;
                if (m_ready) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            var_bus  <= '0;
            lat_cnt  <= '0;
            err      <= 1'b0;
            ready_en <= 1'b0;
            m_pass   <= 1'b0;
            m_err    <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            // Timer reloads whenever we are outside SETTLE, so it always
            // starts from CHECK_LAT on the cycle after the final write.
            if (state != ST_SETTLE) lat_cnt <= LAT_INIT;
            case (state)
                ST_LOAD: begin
                    if (s_hs) begin
                        for (int w = 0; w < FRAME_WORDS; w++) begin
                            if (IDX_W'(w) == idx)
                                var_bus[w*WORD_W +: WORD_W] <= s_data;
                            else if (s_last && (IDX_W'(w) > idx))
                                var_bus[w*WORD_W +: WORD_W] <= '0;
                        end
                        idx <= idx + 1'b1;
                        if (s_last != last_word) err <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (lat_cnt == 4'd0) begin
                        m_pass <= chk_x & ~err;
                        m_err  <= err;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_REPORT: begin
                    if (m_hs) begin
                        if (m_pass) begin
                            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                        end else begin
                            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                        end
                        err <= 1'b0;
                        idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_split_2_assign_loader.sv
// Directed bench for split_2_assign_loader: framing, latency, back-pressure,
// reset and counter saturation, with hand-computed expectations.
module tb_split_2_assign_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  s_data;
    logic         s_last, chk_x;
    logic         s_valid, m_ready, s_valid3, m_ready3;
    logic         s_ready, m_valid, m_pass, m_err;
    logic         s_ready3, m_valid3, m_pass3, m_err3;
    logic [511:0] var_bus, var_bus3, exp_bus;
    logic [15:0]  pass_cnt, fail_cnt;
    logic [1:0]   pass_cnt3, fail_cnt3;

    logic [27:0] var_0;  logic [23:0] var_1;  logic [26:0] var_2;  logic [25:0] var_3;
    logic [16:0] var_4;  logic [19:0] var_5;  logic [29:0] var_6;  logic [24:0] var_7;
    logic [25:0] var_8;  logic [29:0] var_9;  logic [29:0] var_10; logic [31:0] var_11;
    logic [31:0] var_12; logic [20:0] var_13; logic [18:0] var_14; logic [18:0] var_15;
    logic [31:0] var_16; logic [23:0] var_17; logic [25:0] var_18; logic [23:0] var_19;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    split_2_assign_loader #(.WORD_W(32), .CHECK_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .var_bus(var_bus), .chk_x(chk_x),
        .m_valid(m_valid), .m_ready(m_ready), .m_pass(m_pass), .m_err(m_err),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    split_2_assign_loader #(.WORD_W(32), .CHECK_LAT(3), .CNT_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid3), .s_ready(s_ready3),
        .s_data(s_data), .s_last(s_last), .var_bus(var_bus3), .chk_x(chk_x),
        .m_valid(m_valid3), .m_ready(m_ready3), .m_pass(m_pass3), .m_err(m_err3),
        .pass_cnt(pass_cnt3), .fail_cnt(fail_cnt3)
    );

    split_2_assign_unpack u_unpack (
        .var_bus(var_bus),
        .var_0(var_0),   .var_1(var_1),   .var_2(var_2),   .var_3(var_3),
        .var_4(var_4),   .var_5(var_5),   .var_6(var_6),   .var_7(var_7),
        .var_8(var_8),   .var_9(var_9),   .var_10(var_10), .var_11(var_11),
        .var_12(var_12), .var_13(var_13), .var_14(var_14), .var_15(var_15),
        .var_16(var_16), .var_17(var_17), .var_18(var_18), .var_19(var_19)
    );

    task automatic push_word(input bit sel, input logic [31:0] d, input logic l);
        int t = 0;
        s_data = d;
        s_last = l;
        if (sel) s_valid3 = 1'b1; else s_valid = 1'b1;
        while (!(sel ? s_ready3 : s_ready) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL push_timeout: s_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(posedge clk); #1;
        if (sel) s_valid3 = 1'b0; else s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic send_frame(input bit sel, input int n, input int last_at,
                              input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < n; i++)
            push_word(sel, base + step * 32'(i), i == last_at);
    endtask

    task automatic wait_verdict(input bit sel, output int lat);
        lat = 0;
        while (!(sel ? m_valid3 : m_valid) && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 60) begin
            n_cmp++; n_err++;
            $display("FAIL verdict_timeout: m_valid stayed 0 for %0d cycles, required 1", lat);
        end
    endtask

    task automatic ack(input bit sel);
        if (sel) m_ready3 = 1'b1; else m_ready = 1'b1;
        @(posedge clk); #1;
        if (sel) m_ready3 = 1'b0; else m_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if ({s_ready, m_valid, m_pass, m_err} !== 4'b0000) begin n_err++;
            $display("FAIL reset_ctrl: got %b, required 0000", {s_ready, m_valid, m_pass, m_err}); end
        n_cmp++; if (var_bus !== '0 || pass_cnt !== 16'h0 || fail_cnt !== 16'h0) begin n_err++;
            $display("FAIL reset_data: bus_lo=%h pass=%h fail=%h, required 0", var_bus[31:0], pass_cnt, fail_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_err++;
            $display("FAIL reset_first_cycle_ready: got %b, required 0", s_ready); end
        @(posedge clk); #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_second_cycle_ready: got %b, required 1", s_ready); end
    endtask

    task automatic test_well_formed();
        int lat;
        chk_x = 1'b1;
        send_frame(0, 16, 15, 32'h0, 32'h1);
        wait_verdict(0, lat);
        n_cmp++; if (lat !== 2) begin n_err++;
            $display("FAIL wf_latency: got %0d, required 2", lat); end
        n_cmp++; if ({m_pass, m_err} !== 2'b10) begin n_err++;
            $display("FAIL wf_verdict: pass/err got %b, required 10", {m_pass, m_err}); end
        n_cmp++; if (var_bus[31:0] !== 32'h0 || var_bus[511:480] !== 32'hF) begin n_err++;
            $display("FAIL wf_bus: lo=%h hi=%h, required 0 and f", var_bus[31:0], var_bus[511:480]); end
        n_cmp++; if (var_bus[255:224] !== 32'h7) begin n_err++;
            $display("FAIL wf_word7: got %h, required 7", var_bus[255:224]); end
        n_cmp++; if (var_0 !== 28'h0 || var_1 !== 24'h10 || var_19 !== 24'h0) begin n_err++;
            $display("FAIL wf_unpack: var_0=%h var_1=%h var_19=%h, required 0 10 0", var_0, var_1, var_19); end
        ack(0);
        n_cmp++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || m_valid !== 1'b0) begin n_err++;
            $display("FAIL wf_count: pass=%0d fail=%0d m_valid=%b, required 1 0 0", pass_cnt, fail_cnt, m_valid); end
    endtask

    task automatic test_early_last();
        int lat;
        chk_x = 1'b1;
        send_frame(0, 4, 3, 32'hFFFF_FFFF, 32'h0);
        wait_verdict(0, lat);
        exp_bus = '0;
        exp_bus[127:0] = {128{1'b1}};
        n_cmp++; if (var_bus !== exp_bus) begin n_err++;
            $display("FAIL early_bus: got %h", var_bus); end
        n_cmp++; if ({m_pass, m_err} !== 2'b01) begin n_err++;
            $display("FAIL early_verdict: pass/err got %b, required 01", {m_pass, m_err}); end
        n_cmp++; if (var_0 !== 28'hFFF_FFFF || var_1 !== 24'hFF_FFFF || var_2 !== 27'h7FF_FFFF
                     || var_3 !== 26'h3FF_FFFF || var_4 !== 17'h1_FFFF || var_5 !== 20'h3F) begin n_err++;
            $display("FAIL early_unpack_low: v0=%h v1=%h v2=%h v3=%h v4=%h v5=%h", var_0, var_1, var_2, var_3, var_4, var_5); end
        n_cmp++; if ((|{var_6, var_7, var_8, var_9, var_10, var_11, var_12, var_13, var_14,
                        var_15, var_16, var_17, var_18, var_19}) !== 1'b0) begin n_err++;
            $display("FAIL early_unpack_high: upper vars nonzero, required all 0"); end
        ack(0);
        n_cmp++; if (fail_cnt !== 16'd1 || pass_cnt !== 16'd1) begin n_err++;
            $display("FAIL early_count: pass=%0d fail=%0d, required 1 1", pass_cnt, fail_cnt); end
    endtask

    task automatic test_missing_last();
        int lat;
        chk_x = 1'b1;
        send_frame(0, 20, 19, 32'hA000_0000, 32'h1);
        wait_verdict(0, lat);
        n_cmp++; if (var_bus[511:480] !== 32'hA000_000F || var_bus[31:0] !== 32'hA000_0000) begin n_err++;
            $display("FAIL missing_bus: hi=%h lo=%h, required a000000f a0000000", var_bus[511:480], var_bus[31:0]); end
        n_cmp++; if ({m_pass, m_err} !== 2'b01) begin n_err++;
            $display("FAIL missing_verdict: pass/err got %b, required 01", {m_pass, m_err}); end
        ack(0);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (m_valid !== 1'b0) begin n_err++;
                $display("FAIL missing_single_verdict: m_valid=%b at cycle %0d, required 0", m_valid, i); end
            @(posedge clk); #1;
        end
        n_cmp++; if (fail_cnt !== 16'd2) begin n_err++;
            $display("FAIL missing_count: fail=%0d, required 2", fail_cnt); end
    endtask

    task automatic test_chk_low();
        int lat;
        chk_x = 1'b0;
        send_frame(0, 16, 15, 32'h5555_0000, 32'h1);
        wait_verdict(0, lat);
        n_cmp++; if ({m_pass, m_err} !== 2'b00) begin n_err++;
            $display("FAIL chk_low_verdict: pass/err got %b, required 00", {m_pass, m_err}); end
        ack(0);
        n_cmp++; if (fail_cnt !== 16'd3 || pass_cnt !== 16'd1) begin n_err++;
            $display("FAIL chk_low_count: pass=%0d fail=%0d, required 1 3", pass_cnt, fail_cnt); end
    endtask

    task automatic test_back_pressure();
        int lat;
        chk_x = 1'b1;
        send_frame(0, 16, 15, 32'h1234_0000, 32'h1);
        wait_verdict(0, lat);
        chk_x = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if ({m_valid, m_pass, m_err, s_ready} !== 4'b1100) begin n_err++;
                $display("FAIL bp_hold: valid/pass/err/s_ready got %b at cycle %0d, required 1100",
                         {m_valid, m_pass, m_err, s_ready}, i); end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        ack(0);
        n_cmp++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin n_err++;
            $display("FAIL bp_release: s_ready=%b m_valid=%b, required 1 0", s_ready, m_valid); end
        n_cmp++; if (pass_cnt !== 16'd2) begin n_err++;
            $display("FAIL bp_count: pass=%0d, required 2", pass_cnt); end
    endtask

    task automatic lat3_frame(input bit inv, input logic exp_pass);
        int lat = -1;
        send_frame(1, 16, 15, 32'hC000_0000, 32'h1);
        for (int k = 0; k < 8; k++) begin
            chk_x = (k[0] ^ inv);
            @(posedge clk); #1;
            if (m_valid3 && lat < 0) lat = k + 1;
        end
        n_cmp++; if (lat !== 4) begin n_err++;
            $display("FAIL lat3_latency: got %0d, required 4", lat); end
        n_cmp++; if ({m_pass3, m_err3} !== {exp_pass, 1'b0}) begin n_err++;
            $display("FAIL lat3_sample: pass/err got %b, required %b0", {m_pass3, m_err3}, exp_pass); end
        n_cmp++; if (var_bus3[511:480] !== 32'hC000_000F) begin n_err++;
            $display("FAIL lat3_bus: got %h, required c000000f", var_bus3[511:480]); end
        ack(1);
    endtask

    task automatic test_check_lat();
        lat3_frame(1'b0, 1'b1);
        lat3_frame(1'b1, 1'b0);
        n_cmp++; if (pass_cnt3 !== 2'd1 || fail_cnt3 !== 2'd1) begin n_err++;
            $display("FAIL lat3_count: pass=%0d fail=%0d, required 1 1", pass_cnt3, fail_cnt3); end
    endtask

    task automatic test_saturation();
        int lat;
        logic [1:0] exp_cnt [3] = '{2'd2, 2'd3, 2'd3};
        chk_x = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_frame(1, 16, 15, 32'h0, 32'h1);
            wait_verdict(1, lat);
            ack(1);
            n_cmp++; if (pass_cnt3 !== exp_cnt[f]) begin n_err++;
                $display("FAIL sat_count: frame %0d pass=%0d, required %0d", f, pass_cnt3, exp_cnt[f]); end
        end
        n_cmp++; if (fail_cnt3 !== 2'd1) begin n_err++;
            $display("FAIL sat_fail_untouched: fail=%0d, required 1", fail_cnt3); end
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        chk_x = 1'b1;
        send_frame(0, 7, 99, 32'h0000_0300, 32'h1);
        s_data = 32'h0000_0307;
        s_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({s_ready, m_valid, m_pass, m_err} !== 4'b0000 || var_bus !== '0) begin n_err++;
            $display("FAIL midrst_outputs: ctrl=%b bus_lo=%h, required 0000 0", {s_ready, m_valid, m_pass, m_err}, var_bus[31:0]); end
        n_cmp++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || pass_cnt3 !== 2'd0) begin n_err++;
            $display("FAIL midrst_counters: pass=%0d fail=%0d pass3=%0d, required 0", pass_cnt, fail_cnt, pass_cnt3); end
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(0, 16, 15, 32'h0000_0100, 32'h1);
        wait_verdict(0, lat);
        n_cmp++; if ({m_pass, m_err} !== 2'b10 || var_bus[255:224] !== 32'h107) begin n_err++;
            $display("FAIL midrst_frame: pass/err=%b word7=%h, required 10 107", {m_pass, m_err}, var_bus[255:224]); end
        ack(0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (m_valid !== 1'b0) begin n_err++;
                $display("FAIL midrst_single: extra verdict at cycle %0d", i); end
        end
        n_cmp++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin n_err++;
            $display("FAIL midrst_count: pass=%0d fail=%0d, required 1 0", pass_cnt, fail_cnt); end
    endtask

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_valid3 = 1'b0;
        m_ready  = 1'b0;
        m_ready3 = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        chk_x    = 1'b0;
        test_reset();
        test_well_formed();
        test_early_last();
        test_missing_last();
        test_chk_low();
        test_back_pressure();
        test_check_lat();
        test_saturation();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
